// File: rtl/matmul_mkp.sv
// Streams C[M][P] = A[M][K] x B[K][P] from 1-cycle-latency read memories to a C write port.
// One READ cycle per k and one WRITE per element, with a signed/unsigned mode and optional saturation.
module matmul_mkp #(
  parameter int M          = 8,
  parameter int K          = 8,
  parameter int P          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic                  sat_en,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] a_dout,
  output logic [ADDR_WIDTH-1:0] a_rd_addr,
  input  logic [DATA_WIDTH-1:0] b_dout,
  output logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic [DATA_WIDTH-1:0] c_din,
  output logic [ADDR_WIDTH-1:0] c_wr_addr,
  output logic                  c_wr_en
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] M_LAST = ADDR_WIDTH'(M - 1);
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(K - 1);
  localparam logic [ADDR_WIDTH-1:0] P_LAST = ADDR_WIDTH'(P - 1);
  localparam logic [ADDR_WIDTH-1:0] K_A    = ADDR_WIDTH'(K);
  localparam logic [ADDR_WIDTH-1:0] P_A    = ADDR_WIDTH'(P);
  localparam logic [ACC_WIDTH-1:0]  SMAX   = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]  SMIN   = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0]  UMAX   = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    sgn_q, sgn_d, sat_q, sat_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_WIDTH-1:0]   c_addr_q, c_addr_d;
  logic [DATA_WIDTH-1:0]   c_din_q, c_din_d;

  logic [2*DATA_WIDTH-1:0] a_w, b_w, prod_w;
  logic [ACC_WIDTH-1:0]    prod_acc, sum;
  logic [DATA_WIDTH-1:0]   fmt;
  logic [ADDR_WIDTH-1:0]   i_next, j_next;
  logic                    last_col;

  // Operands are sign- or zero-extended so one multiplier serves both modes.
  always_comb begin
    a_w    = {{DATA_WIDTH{sgn_q & a_dout[DATA_WIDTH-1]}}, a_dout};
    b_w    = {{DATA_WIDTH{sgn_q & b_dout[DATA_WIDTH-1]}}, b_dout};
    prod_w = a_w * b_w;
    if (sgn_q) prod_acc = ACC_WIDTH'($signed(prod_w));
    else       prod_acc = ACC_WIDTH'(prod_w);
    sum = acc_q + prod_acc;

    fmt = sum[DATA_WIDTH-1:0];
    if (sat_q) begin
      if (sgn_q) begin
        if ($signed(sum) > $signed(SMAX))      fmt = SMAX[DATA_WIDTH-1:0];
        else if ($signed(sum) < $signed(SMIN)) fmt = SMIN[DATA_WIDTH-1:0];
      end else if (sum > UMAX) begin
        fmt = UMAX[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    // NOTE: every signal is given its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    sgn_d    = sgn_q;
    sat_d    = sat_q;
    busy_d   = busy_q;
    done_d   = done_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    c_din_d  = c_din_q;
    last_col = (j_q == P_LAST);
    j_next   = last_col ? '0 : j_q + ONE;
    i_next   = last_col ? i_q + ONE : i_q;

    unique case (state_q)
      IDLE: if (start) begin
        sgn_d    = signed_mode;
        sat_d    = sat_en;
        i_d      = '0;
        j_d      = '0;
        k_d      = '0;
        a_addr_d = '0;
        b_addr_d = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        state_d  = READ;
      end
      READ: begin
        // Data seen in this cycle belongs to the previous k; k=0 starts a fresh element.
        acc_d = (k_q == '0) ? '0 : sum;
        if (k_q == K_LAST) begin
          state_d = WRITE;
        end else begin
          k_d      = k_q + ONE;
          a_addr_d = i_q * K_A + k_q + ONE;
          b_addr_d = (k_q + ONE) * P_A + j_q;
        end
      end
      WRITE: begin
        c_din_d  = fmt;
        c_addr_d = i_q * P_A + j_q;
        k_d      = '0;
        if (last_col && i_q == M_LAST) begin
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          i_d      = i_next;
          j_d      = j_next;
          a_addr_d = i_next * K_A;
          b_addr_d = j_next;
          state_d  = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments; reset is synchronous, sampled only on the clock edge.
    if (!reset_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      c_din_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      sgn_q    <= sgn_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      c_din_q  <= c_din_d;
    end
  end

  // The write port shows the element in its WRITE cycle and holds it afterwards.
  assign c_wr_en   = (state_q == WRITE);
  assign c_din     = c_din_d;
  assign c_wr_addr = c_addr_d;
  assign a_rd_addr = a_addr_q;
  assign b_rd_addr = b_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_matmul_mkp.sv
// Scoreboard bench for matmul_mkp: an 8x8x8/32-bit instance and a 2x3x4/8-bit instance,
// with expected C computed by plain integer arithmetic over the matrices.
module tb_matmul_mkp;
  localparam int BM = 8, BK = 8, BP = 8, BDW = 32, BACC = 64, BAW = 6;
  localparam int SM = 2, SK = 3, SP = 4, SDW = 8, SACC = 16, SAW = 4;

  typedef struct {
    int          addr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset_n;
  logic start_b, sgn_b, sat_b, busy_b, done_b, c_we_b;
  logic [BDW-1:0] a_dout_b, b_dout_b, c_din_b;
  logic [BAW-1:0] a_addr_b, b_addr_b, c_addr_b;
  logic start_s, sgn_s, sat_s, busy_s, done_s, c_we_s;
  logic [SDW-1:0] a_dout_s, b_dout_s, c_din_s;
  logic [SAW-1:0] a_addr_s, b_addr_s, c_addr_s;

  logic [BDW-1:0] am_b[64], bm_b[64];
  logic [SDW-1:0] am_s[16], bm_s[16];

  exp_t q_b[$], q_s[$];
  exp_t e_b, e_s;
  int   n_checks = 0, n_fail = 0;
  int   wr_b = 0, wr_s = 0, last_b = -1, last_s = -1;
  bit   big_done_exp = 0, small_done_exp = 0;

  matmul_mkp #(.M(BM), .K(BK), .P(BP), .DATA_WIDTH(BDW), .ACC_WIDTH(BACC), .ADDR_WIDTH(BAW)) u_big (
    .clock(clk), .reset_n(reset_n), .start(start_b), .signed_mode(sgn_b), .sat_en(sat_b),
    .busy(busy_b), .done(done_b), .a_dout(a_dout_b), .a_rd_addr(a_addr_b),
    .b_dout(b_dout_b), .b_rd_addr(b_addr_b), .c_din(c_din_b), .c_wr_addr(c_addr_b), .c_wr_en(c_we_b));

  matmul_mkp #(.M(SM), .K(SK), .P(SP), .DATA_WIDTH(SDW), .ACC_WIDTH(SACC), .ADDR_WIDTH(SAW)) u_small (
    .clock(clk), .reset_n(reset_n), .start(start_s), .signed_mode(sgn_s), .sat_en(sat_s),
    .busy(busy_s), .done(done_s), .a_dout(a_dout_s), .a_rd_addr(a_addr_s),
    .b_dout(b_dout_s), .b_rd_addr(b_addr_s), .c_din(c_din_s), .c_wr_addr(c_addr_s), .c_wr_en(c_we_s));

  // Single-port read memories with one cycle of latency.
  always @(posedge clk) begin
    a_dout_b <= am_b[a_addr_b];
    b_dout_b <= bm_b[b_addr_b];
    a_dout_s <= am_s[a_addr_s];
    b_dout_s <= bm_s[b_addr_s];
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mask(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Value of the low w bits of v, read as two's complement when sgn is set.
  function automatic longint sx(logic [63:0] v, int w, bit sgn);
    longint r;
    r = longint'(v & mask(w));
    if (sgn && v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic logic [63:0] fmt(longint s, int dw, int accw, bit sgn, bit sat);
    logic [63:0] u, dm;
    longint      v;
    u  = 64'(s) & mask(accw);
    dm = mask(dw);
    if (!sat) return u & dm;
    if (sgn) begin
      v = sx(u, accw, 1'b1);
      if (v > ((longint'(1) << (dw - 1)) - 1)) return (64'd1 << (dw - 1)) - 64'd1;
      if (v < -(longint'(1) << (dw - 1)))      return 64'(-(longint'(1) << (dw - 1))) & dm;
      return u & dm;
    end
    return (u > dm) ? dm : u;
  endfunction

  always @(negedge clk) begin
    if (c_we_b === 1'b1) begin
      check("big write expected", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        check("big c_wr_addr", 64'(c_addr_b), 64'(e_b.addr));
        check("big c_din", 64'(c_din_b), e_b.data);
      end
      if (last_b >= 0) check("big write spacing", 64'(cyc - last_b), 64'(BK + 1));
      last_b = cyc;
      wr_b++;
    end
    if (c_we_s === 1'b1) begin
      check("small write expected", 64'(q_s.size() != 0), 64'd1);
      if (q_s.size() != 0) begin
        e_s = q_s.pop_front();
        check("small c_wr_addr", 64'(c_addr_s), 64'(e_s.addr));
        check("small c_din", 64'(c_din_s), e_s.data);
      end
      if (last_s >= 0) check("small write spacing", 64'(cyc - last_s), 64'(SK + 1));
      last_s = cyc;
      wr_s++;
    end
  end

  task automatic run_big(bit sgn, bit sat, int glitch_at, int abort_at);
    longint s;
    int     n, done_cyc, pre;
    for (int i = 0; i < BM; i++)
      for (int j = 0; j < BP; j++) begin
        s = 0;
        for (int k = 0; k < BK; k++) s += sx(am_b[i*BK+k], BDW, sgn) * sx(bm_b[k*BP+j], BDW, sgn);
        q_b.push_back('{addr: i * BP + j, data: fmt(s, BDW, BACC, sgn, sat)});
      end
    check("big done before start", 64'(done_b), 64'(big_done_exp));
    last_b = -1;
    wr_b   = 0;
    @(negedge clk);
    start_b = 1'b1; sgn_b = sgn; sat_b = sat;
    @(negedge clk);
    start_b = 1'b0;
    check("big busy after start", 64'(busy_b), 64'd1);
    check("big done after start", 64'(done_b), 64'd0);
    n        = BM * BP * (BK + 1);
    done_cyc = -1;
    for (int c = 1; c <= n + 20; c++) begin
      start_b = (c == glitch_at);
      if (c == glitch_at) begin sgn_b = ~sgn; sat_b = ~sat; end
      if (c == abort_at) reset_n = 1'b0;
      @(negedge clk);
      if (abort_at > 0 && c == abort_at) begin
        reset_n = 1'b1;
        pre = (abort_at - 1) / (BK + 1);
        check("abort busy", 64'(busy_b), 64'd0);
        check("abort done", 64'(done_b), 64'd0);
        check("abort c_wr_en", 64'(c_we_b), 64'd0);
        check("abort a_rd_addr", 64'(a_addr_b), 64'd0);
        check("abort b_rd_addr", 64'(b_addr_b), 64'd0);
        check("abort c_wr_addr", 64'(c_addr_b), 64'd0);
        check("abort c_din", 64'(c_din_b), 64'd0);
        check("abort writes before reset", 64'(wr_b), 64'(pre));
        q_b.delete();
        big_done_exp   = 0;
        small_done_exp = 0;
        repeat (BK + 3) @(negedge clk);
        check("abort no later writes", 64'(wr_b), 64'(pre));
        return;
      end
      if (c == n / 2) check("big busy mid-op", 64'(busy_b), 64'd1);
      if (done_b === 1'b1) begin done_cyc = c; break; end
    end
    check("big done latency", 64'(done_cyc), 64'(n));
    check("big write count", 64'(wr_b), 64'(BM * BP));
    check("big queue drained", 64'(q_b.size()), 64'd0);
    check("big busy after done", 64'(busy_b), 64'd0);
    big_done_exp = 1;
  endtask

  task automatic run_small(bit sgn, bit sat);
    longint s;
    int     n, done_cyc;
    for (int i = 0; i < SM; i++)
      for (int j = 0; j < SP; j++) begin
        s = 0;
        for (int k = 0; k < SK; k++) s += sx(am_s[i*SK+k], SDW, sgn) * sx(bm_s[k*SP+j], SDW, sgn);
        q_s.push_back('{addr: i * SP + j, data: fmt(s, SDW, SACC, sgn, sat)});
      end
    check("small done before start", 64'(done_s), 64'(small_done_exp));
    last_s = -1;
    wr_s   = 0;
    @(negedge clk);
    start_s = 1'b1; sgn_s = sgn; sat_s = sat;
    @(negedge clk);
    start_s = 1'b0;
    check("small done after start", 64'(done_s), 64'd0);
    n        = SM * SP * (SK + 1);
    done_cyc = -1;
    for (int c = 1; c <= n + 20; c++) begin
      @(negedge clk);
      if (done_s === 1'b1) begin done_cyc = c; break; end
    end
    check("small done latency", 64'(done_cyc), 64'(n));
    check("small write count", 64'(wr_s), 64'(SM * SP));
    check("small queue drained", 64'(q_s.size()), 64'd0);
    small_done_exp = 1;
  endtask

  task automatic rand_big();
    logic [BDW-1:0] v;
    for (int x = 0; x < 64; x++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      am_b[x] = v;
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      bm_b[x] = v;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_b = 1'b0; sgn_b = 1'b0; sat_b = 1'b0;
    start_s = 1'b0; sgn_s = 1'b0; sat_s = 1'b0;
    for (int x = 0; x < 16; x++) begin am_s[x] = '0; bm_s[x] = '0; end
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy_b), 64'd0);
    check("reset done", 64'(done_b), 64'd0);
    check("reset c_wr_en", 64'(c_we_b), 64'd0);
    check("reset a_rd_addr", 64'(a_addr_b), 64'd0);
    check("reset c_din", 64'(c_din_b), 64'd0);
    check("reset small busy", 64'(busy_s), 64'd0);
    reset_n = 1'b1;

    // Identity A against a counting B: C must reproduce B.
    for (int r = 0; r < BK; r++)
      for (int c = 0; c < BP; c++) begin
        am_b[r*BK+c] = (r == c) ? 1 : 0;
        bm_b[r*BP+c] = BDW'(r * 8 + c);
      end
    run_big(1'b0, 1'b0, 0, 0);

    rand_big();
    run_big(1'b1, 1'b0, 20, 0);
    rand_big();
    run_big(1'b0, 1'b1, 0, 0);
    rand_big();
    run_big(1'b1, 1'b1, 0, 40);
    run_big(1'b1, 1'b1, 0, 0);

    // 2x3x4: A=[[1,2,3],[4,5,6]], B[r][c]=r+c.
    for (int x = 0; x < 6; x++) am_s[x] = SDW'(x + 1);
    for (int r = 0; r < SK; r++)
      for (int c = 0; c < SP; c++) bm_s[r*SP+c] = SDW'(r + c);
    run_small(1'b0, 1'b0);

    // Signed 2x2 embedded with zero padding: A=[[-1,2],[3,-4]], B=[[5,-6],[7,8]].
    for (int x = 0; x < 16; x++) begin am_s[x] = '0; bm_s[x] = '0; end
    am_s[0] = 8'hFF; am_s[1] = 8'd2; am_s[3] = 8'd3; am_s[4] = 8'hFC;
    bm_s[0] = 8'd5;  bm_s[1] = 8'hFA; bm_s[4] = 8'd7; bm_s[5] = 8'd8;
    run_small(1'b1, 1'b0);

    // Every element is 100*100+100*100 = 20000.
    for (int x = 0; x < 16; x++) begin am_s[x] = '0; bm_s[x] = '0; end
    for (int i = 0; i < SM; i++) begin am_s[i*SK] = 8'd100; am_s[i*SK+1] = 8'd100; end
    for (int c = 0; c < SP; c++) begin bm_s[c] = 8'd100; bm_s[SP+c] = 8'd100; end
    run_small(1'b1, 1'b1);
    run_small(1'b1, 1'b0);
    run_small(1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      for (int x = 0; x < 16; x++) begin am_s[x] = SDW'($urandom); bm_s[x] = SDW'($urandom); end
      run_small(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
